// File: rtl/store_buffer_if.sv
// Port bundle for the store buffer: core store/load lookup side plus memory drain side.
// The core/testbench drives through master; the buffer takes slave.
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             st_valid;
    logic             st_ready;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [2:0]       st_funct3;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic [2:0]       ld_funct3;
    logic             ld_hit;
    logic [31:0]      ld_hit_data;
    logic             ld_stall;
    logic             mem_busy;
    logic             mem_write;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_write_data;
    logic [2:0]       mem_funct3;
    logic             empty;
    logic [PTR_W:0]   count;

    modport master (
        output st_valid, st_addr, st_data, st_funct3,
        output ld_valid, ld_addr, ld_funct3, mem_busy,
        input  st_ready, ld_hit, ld_hit_data, ld_stall,
        input  mem_write, mem_addr, mem_write_data, mem_funct3, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3,
        input  ld_valid, ld_addr, ld_funct3, mem_busy,
        output st_ready, ld_hit, ld_hit_data, ld_stall,
        output mem_write, mem_addr, mem_write_data, mem_funct3, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer: single-cycle enqueue of SB/SH/SW, one drain per cycle to memory,
// and combinational load lookup that forwards exact matches and stalls on partial overlap.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;
    localparam ptr_t PTR_ONE  = ptr_t'(1'b1);
    localparam cnt_t CNT_ONE  = cnt_t'(1'b1);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    function automatic logic [3:0] byte_mask(input logic [1:0] a, input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << a;
            2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [2:0]       f3_q   [DEPTH];
    logic [2:0]       f3_d   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    ptr_t             head_q;
    ptr_t             head_d;
    ptr_t             tail_q;
    ptr_t             tail_d;
    cnt_t             count_q;
    cnt_t             count_d;

    logic             full_s;
    logic             empty_s;
    logic             st_f3_ok_s;
    logic             push_s;
    logic             drain_s;

    assign full_s     = (count_q == CNT_FULL);
    assign empty_s    = (count_q == cnt_t'(1'b0));
    assign st_f3_ok_s = (sb.st_funct3 == 3'b000) || (sb.st_funct3 == 3'b001) ||
                        (sb.st_funct3 == 3'b010);
    // Invalid-size stores still complete the handshake but never occupy a slot.
    assign push_s     = sb.st_valid && !full_s && st_f3_ok_s;
    assign drain_s    = !empty_s && !sb.mem_busy;

    assign sb.st_ready      = !full_s;
    assign sb.empty         = empty_s;
    assign sb.count         = count_q;
    assign sb.mem_write     = drain_s;
    assign sb.mem_addr      = empty_s ? 32'h0000_0000 : addr_q[head_q];
    assign sb.mem_write_data = empty_s ? 32'h0000_0000 : data_q[head_q];
    assign sb.mem_funct3    = empty_s ? 3'b000 : f3_q[head_q];

    // Next-state for entry storage, pointers and occupancy.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        f3_d    = f3_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_s) begin
            addr_d[tail_q]  = sb.st_addr;
            data_d[tail_q]  = sb.st_data;
            f3_d[tail_q]    = sb.st_funct3;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end
        if (drain_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
        case ({push_s, drain_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every buffered store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 32'h0000_0000;
                data_q[i] <= 32'h0000_0000;
                f3_q[i]   <= 3'b000;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            f3_q    <= f3_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    logic        ld_f3_ok_s;
    logic [3:0]  ld_mask_s;
    logic [3:0]  e_mask_s;
    logic [3:0]  f_mask_s;
    logic [1:0]  f_size_s;
    logic [31:0] f_data_s;
    logic        found_s;
    ptr_t        idx_s;
    logic        hit_s;
    logic [31:0] ext_s;

    assign ld_f3_ok_s = (sb.ld_funct3 == 3'b000) || (sb.ld_funct3 == 3'b001) ||
                        (sb.ld_funct3 == 3'b010) || (sb.ld_funct3 == 3'b100) ||
                        (sb.ld_funct3 == 3'b101);
    assign ld_mask_s  = ld_f3_ok_s ? byte_mask(sb.ld_addr[1:0], sb.ld_funct3[1:0]) : 4'b0000;

    // Walk oldest to youngest so the last overlapping entry seen is the youngest one.
    always_comb begin
        found_s  = 1'b0;
        f_mask_s = 4'b0000;
        f_size_s = 2'b00;
        f_data_s = 32'h0000_0000;
        idx_s    = head_q;
        e_mask_s = 4'b0000;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s    = head_q + ptr_t'(i);
            e_mask_s = byte_mask(addr_q[idx_s][1:0], f3_q[idx_s][1:0]);
            if (valid_q[idx_s] && (addr_q[idx_s][31:2] == sb.ld_addr[31:2]) &&
                ((e_mask_s & ld_mask_s) != 4'b0000)) begin
                found_s  = 1'b1;
                f_mask_s = e_mask_s;
                f_size_s = f3_q[idx_s][1:0];
                f_data_s = data_q[idx_s];
            end else begin
                found_s = found_s;
            end
        end
    end

    assign hit_s = found_s && (f_mask_s == ld_mask_s) && (f_size_s == sb.ld_funct3[1:0]);

    // Sign/zero extension of the forwarded store data.
    always_comb begin
        case (sb.ld_funct3)
            3'b000:  ext_s = {{24{f_data_s[7]}}, f_data_s[7:0]};
            3'b001:  ext_s = {{16{f_data_s[15]}}, f_data_s[15:0]};
            3'b010:  ext_s = f_data_s;
            3'b100:  ext_s = {24'h00_0000, f_data_s[7:0]};
            3'b101:  ext_s = {16'h0000, f_data_s[15:0]};
            default: ext_s = 32'h0000_0000;
        endcase
    end

    assign sb.ld_hit      = sb.ld_valid && hit_s;
    assign sb.ld_stall    = sb.ld_valid && found_s && !hit_s;
    assign sb.ld_hit_data = (sb.ld_valid && hit_s) ? ext_s : 32'h0000_0000;
endmodule
